// File: rtl/idct_block_arbiter_if.sv
// Bundle of the requester, core and result streams around idct_block_arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
`ifndef WIN
`define WIN 12
`endif
`ifndef WOUT
`define WOUT 9
`endif

interface idct_block_arbiter_if;
   logic [`WIN*8-1:0]  s0_tdata;
   logic               s0_tvalid;
   logic               s0_tready;
   logic [`WIN*8-1:0]  s1_tdata;
   logic               s1_tvalid;
   logic               s1_tready;
   logic [`WIN*8-1:0]  core_s_tdata;
   logic               core_s_tvalid;
   logic               core_s_tready;
   logic [`WOUT*8-1:0] core_m_tdata;
   logic               core_m_tvalid;
   logic               core_m_tready;
   logic [`WOUT*8-1:0] m_tdata;
   logic               m_tid;
   logic               m_tvalid;
   logic               m_tready;
   logic               busy;
   logic               err;

   modport slave (
      input  s0_tdata, s0_tvalid, s1_tdata, s1_tvalid,
      input  core_s_tready, core_m_tdata, core_m_tvalid, m_tready,
      output s0_tready, s1_tready, core_s_tdata, core_s_tvalid,
      output core_m_tready, m_tdata, m_tid, m_tvalid, busy, err
   );

   modport master (
      output s0_tdata, s0_tvalid, s1_tdata, s1_tvalid,
      output core_s_tready, core_m_tdata, core_m_tvalid, m_tready,
      input  s0_tready, s1_tready, core_s_tdata, core_s_tvalid,
      input  core_m_tready, m_tdata, m_tid, m_tvalid, busy, err
   );
endinterface

// File: rtl/idct_block_arbiter.sv
// Two-requester, 8-row-block arbiter in front of a shared IDCT core, with result tag routing.
// Define IDCT_ARB_PRIO_EN for fixed priority to requester 0; default is round robin.
`ifndef WIN
`define WIN 12
`endif
`ifndef WOUT
`define WOUT 9
`endif

module idct_block_arbiter (
   input logic                 clock,
   input logic                 reset_n,
   idct_block_arbiter_if.slave bus
);
   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e     state_q, state_d;
   logic       gnt_q, gnt_d;
   logic       last_q, last_d;
   logic [2:0] row_cnt_q, row_cnt_d;
   logic [2:0] out_cnt_q, out_cnt_d;
   logic [1:0] tag_mem_q;
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] tag_cnt_q;
   logic       err_q;

   logic pick, push, pop, in_hs, out_hs, fifo_full, fifo_empty;

   assign fifo_full  = (tag_cnt_q == 2'd2);
   assign fifo_empty = (tag_cnt_q == 2'd0);

   // pick = 1 selects requester 1
   always_comb begin
`ifdef IDCT_ARB_PRIO_EN
      pick = ~bus.s0_tvalid;
`else
      if (bus.s0_tvalid && bus.s1_tvalid) pick = ~last_q;
      else                                pick = ~bus.s0_tvalid;
`endif
   end

   always_comb begin
      state_d           = state_q;
      gnt_d             = gnt_q;
      last_d            = last_q;
      row_cnt_d         = row_cnt_q;
      push              = 1'b0;
      in_hs             = 1'b0;
      bus.core_s_tdata  = '0;
      bus.core_s_tvalid = 1'b0;
      bus.s0_tready     = 1'b0;
      bus.s1_tready     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Full FIFO blocks the grant even if the head pops this same cycle.
            if ((bus.s0_tvalid || bus.s1_tvalid) && !fifo_full) begin
               state_d = StXfer;
               gnt_d   = pick;
               last_d  = pick;
               push    = 1'b1;
            end
         end
         StXfer: begin
            bus.core_s_tdata  = gnt_q ? bus.s1_tdata : bus.s0_tdata;
            bus.core_s_tvalid = gnt_q ? bus.s1_tvalid : bus.s0_tvalid;
            bus.s0_tready     = ~gnt_q & bus.core_s_tready;
            bus.s1_tready     = gnt_q & bus.core_s_tready;
            in_hs = (gnt_q ? bus.s1_tvalid : bus.s0_tvalid) && bus.core_s_tready;
            if (in_hs) begin
               row_cnt_d = row_cnt_q + 3'd1;
               if (row_cnt_q == 3'd7) state_d = StIdle;
            end
         end
      endcase
   end

   always_comb begin
      out_hs    = bus.core_m_tvalid && bus.m_tready && !fifo_empty;
      pop       = out_hs && (out_cnt_q == 3'd7);
      out_cnt_d = out_hs ? out_cnt_q + 3'd1 : out_cnt_q;
   end

   assign bus.m_tdata       = bus.core_m_tdata;
   assign bus.m_tid         = !fifo_empty && tag_mem_q[rd_ptr_q];
   assign bus.m_tvalid      = bus.core_m_tvalid && !fifo_empty;
   assign bus.core_m_tready = bus.m_tready && !fifo_empty;
   assign bus.busy          = (state_q != StIdle);
   assign bus.err           = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         row_cnt_q <= 3'd0;
         out_cnt_q <= 3'd0;
         tag_mem_q <= 2'b00;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         tag_cnt_q <= 2'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         row_cnt_q <= row_cnt_d;
         out_cnt_q <= out_cnt_d;
         if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_d;
            wr_ptr_q            <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         tag_cnt_q <= tag_cnt_q + {1'b0, push} - {1'b0, pop};
         // A result with no tag to route it is a protocol fault; it is left unconsumed.
         if (bus.core_m_tvalid && fifo_empty) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_idct_block_arbiter.sv
// Scoreboard bench for idct_block_arbiter: directed blocks, a behavioural core, and a result monitor.
`ifndef WIN
`define WIN 12
`endif
`ifndef WOUT
`define WOUT 9
`endif

module tb_idct_block_arbiter;
   localparam int DW = `WIN * 8;
   localparam int RW = `WOUT * 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   idct_block_arbiter_if bus ();
   idct_block_arbiter dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [RW-1:0] core_q[$];
   logic [RW:0]   exp_q[$];
   logic          en0, en1, mrdy, force_err;
   logic          hs0, hs1, hs_cs, hs_cm, hs_m;
   logic [DW-1:0] cs_data;
   int            n_vec, n_fail, n_cs, first_busy, busy_cnt, n;

   function automatic logic [DW-1:0] mkrow(input int r, input int b, input int k);
      logic [DW-1:0] row;
      for (int i = 0; i < 8; i++) row[i*`WIN +: `WIN] = `WIN'(r * 256 + b * 16 + k + i * 7);
      return row;
   endfunction

   // Stand-in for the IDCT core: truncate and scramble with a fixed pattern.
   function automatic logic [RW-1:0] core_fn(input logic [DW-1:0] x);
      return x[RW-1:0] ^ {(RW/8){8'hA5}};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input int r, input int b);
      for (int k = 0; k < 8; k++) begin
         if (r == 0) q0.push_back(mkrow(r, b, k));
         else        q1.push_back(mkrow(r, b, k));
         exp_q.push_back({1'(r), core_fn(mkrow(r, b, k))});
      end
   endtask

   task automatic drive();
      bus.s0_tvalid     = en0 && (q0.size() > 0);
      bus.s0_tdata      = (q0.size() > 0) ? q0[0] : '0;
      bus.s1_tvalid     = en1 && (q1.size() > 0);
      bus.s1_tdata      = (q1.size() > 0) ? q1[0] : '0;
      bus.core_s_tready = 1'b1;
      bus.core_m_tvalid = force_err || (core_q.size() > 0);
      bus.core_m_tdata  = (core_q.size() > 0) ? core_q[0] : '1;
      bus.m_tready      = mrdy;
   endtask

   task automatic flush();
      q0.delete();
      q1.delete();
      core_q.delete();
      exp_q.delete();
      hs0 = 1'b0; hs1 = 1'b0; hs_cs = 1'b0; hs_cm = 1'b0; hs_m = 1'b0;
   endtask

   // Retire last cycle's handshakes, drive, then sample what fires on the coming edge.
   task automatic step();
      @(negedge clock);
      if (hs0) q0.delete(0);
      if (hs1) q1.delete(0);
      if (hs_cs) core_q.push_back(core_fn(cs_data));
      if (hs_cm) core_q.delete(0);
      drive();
      #1;
      hs0     = bus.s0_tvalid && bus.s0_tready;
      hs1     = bus.s1_tvalid && bus.s1_tready;
      hs_cs   = bus.core_s_tvalid && bus.core_s_tready;
      cs_data = bus.core_s_tdata;
      hs_cm   = bus.core_m_tvalid && bus.core_m_tready;
      hs_m    = bus.m_tvalid && bus.m_tready;
      if (hs_cs) n_cs++;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      flush();
      drive();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic drain(input int limit, input string name);
      int cnt = 0;
      while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0 || core_q.size() > 0)
             && cnt < limit) begin
         step();
         cnt++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   always @(negedge clock) begin
      logic [RW:0] e;
      #2;
      if (reset_n && bus.m_tvalid && bus.m_tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_row", {bus.m_tid, bus.m_tdata}, '1);
         end else begin
            e = exp_q.pop_front();
            check("result_row", {bus.m_tid, bus.m_tdata}, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      n_vec = 0; n_fail = 0; n_cs = 0;
      en0 = 1'b1; en1 = 1'b1; mrdy = 1'b1; force_err = 1'b0;
      flush();
      drive();
      do_reset();
      #1;
      check("rst_s_tready", {bus.s0_tready, bus.s1_tready}, 0);
      check("rst_core_s_tvalid", bus.core_s_tvalid, 0);
      check("rst_core_m_tready", bus.core_m_tready, 0);
      check("rst_m_tvalid", bus.m_tvalid, 0);
      check("rst_m_tid", bus.m_tid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_err", bus.err, 0);

      // Single block from requester 0.
      issue(0, 0);
      first_busy = -1; busy_cnt = 0; n_cs = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (k == 0) check("idle_no_forward", {bus.s0_tready, bus.core_s_tvalid}, 0);
         if (bus.busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = k;
         end
      end
      check("grant_latency", first_busy, 1);
      check("busy_cycles", busy_cnt, 8);
      check("rows_forwarded", n_cs, 8);
      check("fifo_empty_after", bus.core_m_tready, 0);
      check("single_drained", exp_q.size(), 0);

      // Contention: both requesters hold four blocks each.
      do_reset();
`ifdef IDCT_ARB_PRIO_EN
      for (int b = 0; b < 4; b++) issue(0, b);
      for (int b = 0; b < 4; b++) issue(1, b);
`else
      for (int b = 0; b < 4; b++) begin
         issue(0, b);
         issue(1, b);
      end
`endif
      drain(400, "contention");

      // Back-pressure: two tags fill the FIFO, the third grant waits for the first pop.
      do_reset();
      mrdy = 1'b0;
`ifdef IDCT_ARB_PRIO_EN
      issue(0, 0); issue(0, 1); issue(1, 0);
`else
      issue(0, 0); issue(1, 0); issue(0, 1);
`endif
      repeat (30) step();
      check("bp_idle_blocked", bus.busy, 0);
      check("bp_tready_low", {bus.s0_tready, bus.s1_tready}, 0);
      check("bp_rows_left", q0.size() + q1.size(), 8);
      mrdy = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && n < 8; i++) begin
         step();
         if (hs_m) n++;
      end
      check("bp_first_block_out", n, 8);
      step();
      check("bp_no_push_on_pop", bus.busy, 0);
      step();
      check("bp_grant_after_pop", bus.busy, 1);
      drain(200, "bp");

      // Requester 0 stalls mid-block; the grant must hold.
      do_reset();
      issue(0, 3); issue(1, 3);
      n = 0;
      while (q0.size() > 5 && n < 20) begin step(); n++; end
      en0 = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_busy", bus.busy, 1);
         check("stall_no_switch", {bus.s1_tready, bus.core_s_tvalid}, 0);
      end
      en0 = 1'b1;
      drain(100, "stall");

      // Orphan result raises sticky err; async reset mid-block clears everything.
      do_reset();
      force_err = 1'b1;
      step();
      check("err_no_consume", {bus.core_m_tready, bus.m_tvalid}, 0);
      check("err_not_yet", bus.err, 0);
      step();
      check("err_set", bus.err, 1);
      force_err = 1'b0;
      step(); step();
      check("err_sticky", bus.err, 1);
      issue(0, 5);
      n = 0;
      while (q0.size() > 4 && n < 20) begin step(); n++; end
      check("row4_reached", q0.size(), 4);
      #2 reset_n = 1'b0;
      flush();
      drive();
      #1;
      check("arst_err", bus.err, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_fifo_empty", bus.core_m_tready, 0);
      check("arst_outputs", {bus.s0_tready, bus.core_s_tvalid, bus.m_tvalid}, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      issue(1, 6);
      drain(60, "recover");
      check("recover_no_err", bus.err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
